// File: rtl/axi_dma_burst_writer_if.sv
// AXI3 write-side bundle between the DMA burst writer (master) and the HP port (slave).
// Only the AW, W and B channels carry traffic; arvalid/rready exist so the
// master can tie the read side off.
interface axi_ifc;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [3:0]  awcache;
   logic [1:0]  awlock;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic        arvalid;
   logic        rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awcache, awlock, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output arvalid, rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awcache, awlock, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  arvalid, rready
   );
endinterface

// File: rtl/axi_dma_burst_writer.sv
// Multi-burst AXI3 write DMA. One request (address, word count) is cut into
// INCR bursts of at most MAXBURST beats that never cross a 4KB page. The AW
// channel runs ahead of W by up to OUTSTANDING bursts; burst lengths travel
// from AW to W through a small length queue. B responses fold into a sticky
// error flag.
//
// Handshake rule on every channel: a transfer happens in a cycle where
// valid & ready are both 1 at posedge clk. Once valid is raised, valid and its
// payload stay constant until that transfer; ready may change freely.
module axi_dma_burst_writer #(
   parameter int MAXBURST    = 16,
   parameter int LENW        = 16,
   parameter int OUTSTANDING = 4
) (
   input  logic            clk,
   input  logic            reset,
   axi_ifc.master          m,
   input  logic            start,
   input  logic [31:0]     addr,
   input  logic [LENW-1:0] count,
   input  logic [31:0]     data,
   output logic            advance,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic            state_dbg
);

   localparam int WL = LENW + 1;
   localparam int QW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int FW = $clog2(OUTSTANDING + 1);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t        state;
   logic [31:0]   cur_addr;      // byte address of the next burst to issue
   logic [WL-1:0] words_left;    // words not yet covered by an accepted AW
   logic [4:0]    aw_l;          // length of the burst currently on AW
   logic [FW-1:0] in_flight;     // AW accepted, B not yet received
   logic [4:0]    len_q [OUTSTANDING];
   logic [QW-1:0] wr_ptr;
   logic [QW-1:0] rd_ptr;
   logic [FW-1:0] q_cnt;
   logic [4:0]    beat_cnt;      // beat index inside the head burst

   logic [31:0]   start_addr;
   logic [WL-1:0] start_words;
   logic [4:0]    start_len;
   logic [4:0]    start_len_m1;
   logic [4:0]    next_len;
   logic [4:0]    next_len_m1;
   logic          aw_hs;
   logic          w_hs;
   logic          b_hs;
   logic          w_pop;

   // Burst length: smallest of MAXBURST, remaining words and words left in the 4KB page.
   function automatic logic [4:0] burst_len(input logic [9:0] word_in_page,
                                            input logic [WL-1:0] words);
      logic [31:0] l;
      logic [31:0] room;
      logic [31:0] w;
      room = 32'd1024 - {22'd0, word_in_page};
      w    = 32'(words);
      l    = 32'(MAXBURST);
      if (w < l)
         l = w;
      if (room < l)
         l = room;
      return l[4:0];
   endfunction

   function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
      return (p == QW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign start_addr   = addr & ~32'd3;
   assign start_words  = WL'(count) + WL'(1);
   assign start_len    = burst_len(start_addr[11:2], start_words);
   assign start_len_m1 = start_len - 5'd1;
   assign next_len     = burst_len(cur_addr[11:2], words_left);
   assign next_len_m1  = next_len - 5'd1;

   assign aw_hs = m.awvalid & m.awready;
   assign w_hs  = m.wvalid & m.wready;
   assign b_hs  = m.bvalid & m.bready;
   assign w_pop = w_hs & m.wlast;

   assign m.awid    = '0;
   assign m.awsize  = 3'd2;
   assign m.awburst = 2'd1;
   assign m.awcache = '0;
   assign m.awlock  = '0;
   assign m.wid     = '0;
   assign m.wstrb   = 4'hF;
   assign m.wdata   = data;
   assign m.arvalid = 1'b0;
   assign m.rready  = 1'b0;
   assign m.bready  = busy;
   // W beats exist exactly while a burst length is queued; wlast marks its final beat.
   assign m.wvalid  = (q_cnt != '0);
   assign m.wlast   = m.wvalid && (beat_cnt == len_q[rd_ptr] - 5'd1);
   assign advance   = w_hs;
   assign state_dbg = (state == S_ACTIVE);

   // Transfer FSM with AW issue, length queue, W beat tracking and B retirement.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         m.awvalid  <= 1'b0;
         m.awaddr   <= '0;
         m.awlen    <= '0;
         cur_addr   <= '0;
         words_left <= '0;
         aw_l       <= '0;
         in_flight  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         q_cnt      <= '0;
         beat_cnt   <= '0;
         for (int i = 0; i < OUTSTANDING; i++)
            len_q[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_ACTIVE;
                  busy       <= 1'b1;
                  error      <= 1'b0;
                  cur_addr   <= start_addr;
                  words_left <= start_words;
                  aw_l       <= start_len;
                  m.awvalid  <= 1'b1;
                  m.awaddr   <= start_addr;
                  m.awlen    <= start_len_m1[3:0];
               end
            end
            S_ACTIVE: begin
               // AW: retire the offered burst, or offer the next one if the window allows.
               if (aw_hs) begin
                  cur_addr      <= cur_addr + {25'd0, aw_l, 2'b00};
                  words_left    <= words_left - WL'(aw_l);
                  len_q[wr_ptr] <= aw_l;
                  wr_ptr        <= ptr_inc(wr_ptr);
                  m.awvalid     <= 1'b0;
               end else if (!m.awvalid && words_left != '0 &&
                            in_flight < FW'(OUTSTANDING)) begin
                  m.awvalid <= 1'b1;
                  m.awaddr  <= cur_addr;
                  m.awlen   <= next_len_m1[3:0];
                  aw_l      <= next_len;
               end

               if (aw_hs && !w_pop)
                  q_cnt <= q_cnt + 1'b1;
               else if (!aw_hs && w_pop)
                  q_cnt <= q_cnt - 1'b1;

               if (w_hs) begin
                  if (m.wlast) begin
                     beat_cnt <= '0;
                     rd_ptr   <= ptr_inc(rd_ptr);
                  end else begin
                     beat_cnt <= beat_cnt + 5'd1;
                  end
               end

               if (aw_hs && !b_hs)
                  in_flight <= in_flight + 1'b1;
               else if (!aw_hs && b_hs)
                  in_flight <= in_flight - 1'b1;

               if (b_hs && m.bresp != 2'b00)
                  error <= 1'b1;

               // Last response of the last burst ends the transfer.
               if (b_hs && in_flight == FW'(1) && words_left == '0 && !m.awvalid) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
